// File: rtl/arm_servo_pkg.sv
// Shared constants, widths and channel state encoding for the three-axis servo controller.
package arm_servo_pkg;

    localparam int unsigned FRAME_CYCLES_DEF = 1000000;
    localparam int unsigned MIN_PULSE_DEF    = 25000;
    localparam int unsigned STEP_CYC_DEF     = 5555;
    localparam int unsigned MAX_POS_DEF      = 18;
    localparam int unsigned HOME_POS_DEF     = 9;
    localparam int unsigned SLEW_FRAMES_DEF  = 5;

    localparam int unsigned POS_W   = 5;
    localparam int unsigned WIDTH_W = 21;

    typedef enum logic {StIdle, StMoving} ch_state_e;

    function automatic logic [WIDTH_W-1:0] pulse_width(input logic [POS_W-1:0] pos,
                                                       input int unsigned min_pulse,
                                                       input int unsigned step_cyc);
        return WIDTH_W'(min_pulse) + WIDTH_W'(pos) * WIDTH_W'(step_cyc);
    endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo axis: target clamp/latch, slew-limited position FSM, frame-aligned width and PWM.
module servo_channel
    import arm_servo_pkg::*;
#(
    parameter int unsigned MIN_PULSE   = MIN_PULSE_DEF,
    parameter int unsigned STEP_CYC    = STEP_CYC_DEF,
    parameter int unsigned MAX_POS     = MAX_POS_DEF,
    parameter int unsigned HOME_POS    = HOME_POS_DEF,
    parameter int unsigned SLEW_FRAMES = SLEW_FRAMES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_end,
    input  logic [WIDTH_W-1:0] frame_cnt,
    input  logic               hold,
    input  logic [15:0]        pos,
    output logic               pwm,
    // Next-state MOVING flag, so the registered busy at the top changes with the FSM.
    output logic               moving
);

    localparam int unsigned SLEW_W = (SLEW_FRAMES > 2) ? $clog2(SLEW_FRAMES) : 1;

    ch_state_e          state_q, state_d;
    logic [POS_W-1:0]   tgt_q, tgt_d;
    logic [POS_W-1:0]   cur_q, cur_d;
    logic [SLEW_W-1:0]  slew_q, slew_d;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic               pwm_q;

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cur_d   = cur_q;
        slew_d  = slew_q;
        width_d = width_q;
        if (frame_end) begin
            if (!hold) begin
                tgt_d = (pos > 16'(MAX_POS)) ? POS_W'(MAX_POS) : pos[POS_W-1:0];
            end
            case (state_q)
                StIdle: begin
                    slew_d = '0;
                    if (tgt_d != cur_q) state_d = StMoving;
                end
                StMoving: begin
                    // Direction is taken from the freshly sampled target, so reversals
                    // flip at the next step without disturbing the slew count.
                    if (slew_q == SLEW_W'(SLEW_FRAMES - 1)) begin
                        slew_d = '0;
                        if (tgt_d > cur_q) begin
                            cur_d = cur_q + POS_W'(1);
                        end else if (tgt_d < cur_q) begin
                            cur_d = cur_q - POS_W'(1);
                        end
                    end else begin
                        slew_d = slew_q + SLEW_W'(1);
                    end
                    if (cur_d == tgt_d) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
            width_d = pulse_width(cur_d, MIN_PULSE, STEP_CYC);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            tgt_q   <= POS_W'(HOME_POS);
            cur_q   <= POS_W'(HOME_POS);
            slew_q  <= '0;
            width_q <= pulse_width(POS_W'(HOME_POS), MIN_PULSE, STEP_CYC);
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            slew_q  <= slew_d;
            width_q <= width_d;
            pwm_q   <= (frame_cnt < width_q);
        end
    end

    assign pwm    = pwm_q;
    assign moving = (state_d == StMoving);

endmodule

// File: rtl/arm_servo_ctrl.sv
// Three-axis 50 Hz servo driver: shared frame counter, frame strobe and busy flag over three channels.
module arm_servo_ctrl
    import arm_servo_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int unsigned MIN_PULSE    = MIN_PULSE_DEF,
    parameter int unsigned STEP_CYC     = STEP_CYC_DEF,
    parameter int unsigned MAX_POS      = MAX_POS_DEF,
    parameter int unsigned HOME_POS     = HOME_POS_DEF,
    parameter int unsigned SLEW_FRAMES  = SLEW_FRAMES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pos_x,
    input  logic [15:0] pos_y,
    input  logic [15:0] pos_z,
    input  logic        hold,
    output logic        pwm_x,
    output logic        pwm_y,
    output logic        pwm_z,
    output logic        frame_strobe,
    output logic        busy
);

    logic [WIDTH_W-1:0] frame_cnt_q;
    logic               frame_end;
    logic               strobe_q;
    logic               busy_q;
    logic               moving_x, moving_y, moving_z;

    assign frame_end = (frame_cnt_q == WIDTH_W'(FRAME_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            strobe_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            frame_cnt_q <= frame_end ? '0 : frame_cnt_q + WIDTH_W'(1);
            strobe_q    <= (frame_cnt_q == '0);
            busy_q      <= moving_x | moving_y | moving_z;
        end
    end

    servo_channel #(
        .MIN_PULSE   (MIN_PULSE),
        .STEP_CYC    (STEP_CYC),
        .MAX_POS     (MAX_POS),
        .HOME_POS    (HOME_POS),
        .SLEW_FRAMES (SLEW_FRAMES)
    ) u_chan_x (
        .clk       (clk),
        .rst       (rst),
        .frame_end (frame_end),
        .frame_cnt (frame_cnt_q),
        .hold      (hold),
        .pos       (pos_x),
        .pwm       (pwm_x),
        .moving    (moving_x)
    );

    servo_channel #(
        .MIN_PULSE   (MIN_PULSE),
        .STEP_CYC    (STEP_CYC),
        .MAX_POS     (MAX_POS),
        .HOME_POS    (HOME_POS),
        .SLEW_FRAMES (SLEW_FRAMES)
    ) u_chan_y (
        .clk       (clk),
        .rst       (rst),
        .frame_end (frame_end),
        .frame_cnt (frame_cnt_q),
        .hold      (hold),
        .pos       (pos_y),
        .pwm       (pwm_y),
        .moving    (moving_y)
    );

    servo_channel #(
        .MIN_PULSE   (MIN_PULSE),
        .STEP_CYC    (STEP_CYC),
        .MAX_POS     (MAX_POS),
        .HOME_POS    (HOME_POS),
        .SLEW_FRAMES (SLEW_FRAMES)
    ) u_chan_z (
        .clk       (clk),
        .rst       (rst),
        .frame_end (frame_end),
        .frame_cnt (frame_cnt_q),
        .hold      (hold),
        .pos       (pos_z),
        .pwm       (pwm_z),
        .moving    (moving_z)
    );

    assign frame_strobe = strobe_q;
    assign busy         = busy_q;

endmodule
